// File: rtl/game_screen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_screen_ctrl
// Brief    : Game state sequencer (idle/play/win/lose) with frame-aligned
//            overlay pixel selection for the VGA output.
// Revision : 1.0 - initial release
// ============================================================================
module game_screen_ctrl #(
    parameter int WIN_SCORE   = 50,
    parameter int HOLD_FRAMES = 180,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic        video_on,
    input  logic        start_btn,
    input  logic        crash,
    input  logic [5:0]  score_in,
    input  logic [11:0] start_pix,
    input  logic [11:0] play_pix,
    input  logic [11:0] win_pix,
    input  logic [11:0] lose_pix,
    output logic [11:0] pix_out,
    output logic        game_run,
    output logic        game_reset,
    output logic [1:0]  state_out
);

    localparam logic [1:0]       c_st_idle   = 2'd0;
    localparam logic [1:0]       c_st_play   = 2'd1;
    localparam logic [1:0]       c_st_win    = 2'd2;
    localparam logic [1:0]       c_st_lose   = 2'd3;
    localparam logic [5:0]       c_win_score = 6'(WIN_SCORE);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_FRAMES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_disp;
    logic             r_btn_prev;
    logic             r_go;
    logic             r_game_reset;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [11:0]      r_pix;
    logic [11:0]      w_scr_pix;
    logic             w_btn_rise;
    logic             w_in_hold;
    logic             w_hold_done;
    logic             w_go;

    assign w_btn_rise  = start_btn & ~r_btn_prev;
    assign w_in_hold   = (r_state == c_st_win) || (r_state == c_st_lose);
    assign w_hold_done = w_in_hold && frame_tick && (r_hold_cnt == c_hold_last);
    // Only idle->play and hold-expiry->idle leave a non-play state; both restart the game.
    assign w_go        = (r_state != c_st_play) && (w_state_nxt != r_state);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_btn_rise) w_state_nxt = c_st_play;
            end
            c_st_play: begin
                if (score_in >= c_win_score) w_state_nxt = c_st_win;
                else if (crash)              w_state_nxt = c_st_lose;
            end
            default: begin
                if (w_hold_done) w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_comb begin
        game_run  = (r_state == c_st_play);
        state_out = r_state;
        case (r_disp)
            c_st_idle: w_scr_pix = start_pix;
            c_st_play: w_scr_pix = play_pix;
            c_st_win:  w_scr_pix = win_pix;
            default:   w_scr_pix = lose_pix;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_prev   <= 1'b0;
            r_go         <= 1'b0;
            r_game_reset <= 1'b0;
            r_hold_cnt   <= '0;
            r_disp       <= c_st_idle;
            r_pix        <= 12'h000;
        end else begin
            r_btn_prev   <= start_btn;
            r_go         <= w_go;
            r_game_reset <= r_go;
            if (!w_in_hold || w_hold_done) begin
                r_hold_cnt <= '0;
            end else if (frame_tick) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            // Next state is latched so a change on the tick cycle shows this frame.
            if (frame_tick) begin
                r_disp <= w_state_nxt;
            end
            r_pix <= video_on ? w_scr_pix : 12'h000;
        end
    end

    assign pix_out    = r_pix;
    assign game_reset = r_game_reset;

endmodule
`default_nettype wire
